// File: rtl/led_scan_pkg.sv
// led_scan_pkg
// Shared definitions for the LED matrix scan controller: the scan state
// encoding, board-default geometry and timing, and a row one-hot helper.
// No ports; imported by led_frame_buf and led_matrix_scan.
package led_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

  localparam int ROWS_DEF         = 4;
  localparam int COLS_DEF         = 4;
  localparam int ROW_CYCLES_DEF   = 12000;
  localparam int BLANK_CYCLES_DEF = 48;
  localparam int DIM_PHASES       = 16;

  // Widest row count the one-hot helper supports; callers slice what they need.
  localparam int MAX_ROWS = 32;

  function automatic logic [MAX_ROWS-1:0] row_onehot(input int row);
    row_onehot = MAX_ROWS'(1) << row;
  endfunction

endpackage

// File: rtl/led_frame_buf.sv
// led_frame_buf
// Double buffer for the LED frame. A frame is accepted into the shadow
// register whenever the shadow is free, and is copied into the active
// register only on the swap strobe, so the displayed frame never tears.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   frame_data   incoming frame (W bits)
//   frame_valid  frame_data offered
//   swap_i       frame-boundary strobe from the scanner
//   frame_ready  shadow free (= !pending)
//   active_o     frame currently being displayed
module led_frame_buf
  import led_scan_pkg::*;
#(
  parameter int W = ROWS_DEF * COLS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] frame_data,
  input  logic         frame_valid,
  input  logic         swap_i,
  output logic         frame_ready,
  output logic [W-1:0] active_o
);

  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] active_q, active_d;
  logic         pending_q, pending_d;
  logic         xfer;

  assign xfer = frame_valid && !pending_q;

  // A transfer needs pending=0 and a swap only acts with pending=1, so the two
  // never collide on the same buffer; the swap always sees the old shadow.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (swap_i && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (xfer) begin
      shadow_d  = frame_data;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign frame_ready = !pending_q;
  assign active_o    = active_q;

endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan
// Time-multiplexed scan controller for a ROWS x COLS LED matrix. Each row is
// preceded by BLANK_CYCLES of all-off dead time, then driven for ROW_CYCLES.
// All outputs are registered from next-state values.
// Optional build macro LEDSCAN_DIM_EN adds a 4-bit brightness input that gates
// kled_oe over 16 equal phases of each row's drive time.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   enable       1 = scanning, 0 = matrix dark
//   frame_data   new frame, bit r*COLS+c = pixel (r,c)
//   frame_valid  frame_data offered
//   frame_ready  shadow buffer free
//   brightness   (LEDSCAN_DIM_EN only) duty 0..15 -> 1/16..16/16
//   aled_o       one-hot anode row drive
//   kled_oe      cathode output enables for the active row
//   frame_sync   one-cycle pulse on the first blank cycle of row 0
//
// state | meaning
// IDLE  | matrix dark, waiting for enable
// BLANK | dead time before a row, all outputs off
// DRIVE | current row driven from the active buffer
module led_matrix_scan
  import led_scan_pkg::*;
#(
  parameter int ROWS         = ROWS_DEF,
  parameter int COLS         = COLS_DEF,
  parameter int ROW_CYCLES   = ROW_CYCLES_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] frame_data,
  input  logic                 frame_valid,
  output logic                 frame_ready,
`ifdef LEDSCAN_DIM_EN
  input  logic [3:0]           brightness,
`endif
  output logic [ROWS-1:0]      aled_o,
  output logic [COLS-1:0]      kled_oe,
  output logic                 frame_sync
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RCW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [RW-1:0]  ROW_MAX    = RW'(ROWS - 1);
  localparam logic [RCW-1:0] ROW_LAST   = RCW'(ROW_CYCLES - 1);
  localparam logic [BCW-1:0] BLANK_LAST = BCW'(BLANK_CYCLES - 1);

  scan_state_e          state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [RCW-1:0]       rcnt_q, rcnt_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic [ROWS-1:0]      aled_q, aled_d;
  logic [COLS-1:0]      kled_q, kled_d;
  logic                 sync_q, sync_d;
  logic                 frame_start;
  logic                 dim_lit;
  logic [ROWS*COLS-1:0] active;
  logic [ROWS*COLS-1:0] act_sh;
  logic [MAX_ROWS-1:0]  row_oh;

  led_frame_buf #(.W(ROWS * COLS)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .swap_i      (frame_start),
    .frame_ready (frame_ready),
    .active_o    (active)
  );

`ifdef LEDSCAN_DIM_EN
  localparam int PHASE_CYC = ROW_CYCLES / DIM_PHASES;
  logic [3:0] bright_q, bright_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bright_q <= '0;
    else        bright_q <= bright_d;
  end
`endif

  // Timers load on state entry and count down to a terminal count of zero.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    rcnt_d      = rcnt_q;
    bcnt_d      = bcnt_q;
    frame_start = 1'b0;
`ifdef LEDSCAN_DIM_EN
    bright_d    = bright_q;
`endif
    if (!enable) begin
      state_d = IDLE;
      row_d   = '0;
      rcnt_d  = '0;
      bcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = BLANK;
          row_d       = '0;
          bcnt_d      = BLANK_LAST;
          frame_start = 1'b1;
        end
        BLANK: begin
          if (bcnt_q == '0) begin
            state_d = DRIVE;
            rcnt_d  = ROW_LAST;
`ifdef LEDSCAN_DIM_EN
            bright_d = brightness;
`endif
          end else begin
            bcnt_d = bcnt_q - BCW'(1);
          end
        end
        DRIVE: begin
          if (rcnt_q == '0) begin
            state_d = BLANK;
            bcnt_d  = BLANK_LAST;
            if (row_q == ROW_MAX) begin
              row_d       = '0;
              frame_start = 1'b1;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            rcnt_d = rcnt_q - RCW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          row_d   = '0;
          rcnt_d  = '0;
          bcnt_d  = '0;
        end
      endcase
    end
  end

  // Outputs are computed from next state so the registered copies line up
  // with the state register. The active buffer only changes on entry to a
  // frame-start BLANK, never on a DRIVE entry, so active is safe to use here.
  always_comb begin
    row_oh  = row_onehot(int'(row_d));
    act_sh  = active >> (COLS * int'(row_d));
`ifdef LEDSCAN_DIM_EN
    // rcnt counts down from ROW_LAST: lit while elapsed < (brightness+1) phases.
    dim_lit = (int'(rcnt_d) >= ROW_CYCLES - (int'(bright_d) + 1) * PHASE_CYC);
`else
    dim_lit = 1'b1;
`endif
    aled_d  = '0;
    kled_d  = '0;
    sync_d  = frame_start;
    if (state_d == DRIVE) begin
      aled_d = row_oh[ROWS-1:0];
      kled_d = dim_lit ? act_sh[COLS-1:0] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      rcnt_q  <= '0;
      bcnt_q  <= '0;
      aled_q  <= '0;
      kled_q  <= '0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rcnt_q  <= rcnt_d;
      bcnt_q  <= bcnt_d;
      aled_q  <= aled_d;
      kled_q  <= kled_d;
      sync_q  <= sync_d;
    end
  end

  assign aled_o     = aled_q;
  assign kled_oe    = kled_q;
  assign frame_sync = sync_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan
// Directed bench for led_matrix_scan with ROW_CYCLES=32, BLANK_CYCLES=4
// (36-cycle rows, 144-cycle frames). Inputs change and outputs are sampled
// on the falling edge. A small frame-position model supplies per-cycle
// expectations; hand-computed spot checks pin the key points.
module tb_led_matrix_scan;

  localparam int RC = 32;
  localparam int BC = 4;
  localparam int FR = RC + BC;
  localparam int FP = 4 * FR;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [3:0]  aled_o;
  logic [3:0]  kled_oe;
  logic        frame_sync;
`ifdef LEDSCAN_DIM_EN
  logic [3:0]  brightness;
  logic [3:0]  m_bright;
`endif

  int tests = 0;
  int fails = 0;

  // frame-position model
  bit          m_on;
  int          m_k;
  bit          m_pend;
  logic [15:0] m_active;
  logic [15:0] m_shadow;

  led_matrix_scan #(
    .ROWS         (4),
    .COLS         (4),
    .ROW_CYCLES   (RC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
`ifdef LEDSCAN_DIM_EN
    .brightness  (brightness),
`endif
    .aled_o      (aled_o),
    .kled_oe     (kled_oe),
    .frame_sync  (frame_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_on     = 1'b0;
    m_k      = 0;
    m_pend   = 1'b0;
    m_active = '0;
    m_shadow = '0;
`ifdef LEDSCAN_DIM_EN
    m_bright = '0;
`endif
  endtask

  // Check current outputs against the model, advance the model across the
  // coming rising edge using the present inputs, then move to the next falling edge.
  task automatic cyc();
    int          row, pos;
    logic [3:0]  ea, ek;
    logic        es;
    bit          old_p, bnd;
    ea = '0; ek = '0; es = 1'b0;
    if (m_on) begin
      row = m_k / FR;
      pos = m_k % FR;
      es  = (m_k == 0);
      if (pos >= BC) begin
        ea = 4'b0001 << row;
        ek = m_active[row*4 +: 4];
`ifdef LEDSCAN_DIM_EN
        if ((pos - BC) >= (int'(m_bright) + 1) * (RC / 16)) ek = '0;
`endif
      end
    end
    chk("aled", 32'(aled_o), 32'(ea));
    chk("kled", 32'(kled_oe), 32'(ek));
    chk("sync", 32'(frame_sync), 32'(es));
    chk("ready", 32'(frame_ready), 32'(!m_pend));
    old_p = m_pend;
    bnd   = 1'b0;
    if (!enable) begin
      m_on = 1'b0;
    end else if (!m_on) begin
      m_on = 1'b1;
      m_k  = 0;
      bnd  = 1'b1;
    end else begin
      m_k = (m_k + 1) % FP;
      bnd = (m_k == 0);
    end
`ifdef LEDSCAN_DIM_EN
    if (m_on && (m_k % FR) == BC) m_bright = brightness;
`endif
    if (bnd && old_p) begin
      m_active = m_shadow;
      m_pend   = 1'b0;
    end
    if (frame_valid && !old_p) begin
      m_shadow = frame_data;
      m_pend   = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    frame_valid = 1'b0;
    frame_data  = '0;
`ifdef LEDSCAN_DIM_EN
    brightness  = 4'hF;
`endif
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_aled", 32'(aled_o), 32'h0);
    chk("rst_kled", 32'(kled_oe), 32'h0);
    chk("rst_sync", 32'(frame_sync), 32'h0);
    chk("rst_ready", 32'(frame_ready), 32'h1);
    rst_n = 1'b1;
    repeat (2) cyc();

    // load 8421 while idle, then enable: first frame shows it
    frame_valid = 1'b1;
    frame_data  = 16'h8421;
    cyc();
    frame_valid = 1'b0;
    chk("ready_after_load", 32'(frame_ready), 32'h0);
    enable = 1'b1;
    cyc();
    chk("first_sync", 32'(frame_sync), 32'h1);
    chk("ready_after_swap", 32'(frame_ready), 32'h1);
    repeat (BC) cyc();
    chk("r0_aled", 32'(aled_o), 32'h1);
    chk("r0_kled", 32'(kled_oe), 32'h1);
    repeat (FR) cyc();
    chk("r1_aled", 32'(aled_o), 32'h2);
    chk("r1_kled", 32'(kled_oe), 32'h2);
    repeat (FR) cyc();
    chk("r2_aled", 32'(aled_o), 32'h4);
    chk("r2_kled", 32'(kled_oe), 32'h4);
    repeat (FR) cyc();
    chk("r3_aled", 32'(aled_o), 32'h8);
    chk("r3_kled", 32'(kled_oe), 32'h8);
    repeat (RC) cyc();
    chk("sync_period", 32'(frame_sync), 32'h1);

    // mid-frame transfer: current frame keeps old data
    repeat (50) cyc();
    frame_valid = 1'b1;
    frame_data  = 16'hFFFF;
    cyc();
    frame_valid = 1'b0;
    chk("mid_ready", 32'(frame_ready), 32'h0);
    chk("mid_old_kled", 32'(kled_oe), 32'h2);
    repeat (FP - 51) cyc();
    chk("swap_ready", 32'(frame_ready), 32'h1);
    chk("swap_sync", 32'(frame_sync), 32'h1);
    repeat (BC) cyc();
    chk("ffff_kled", 32'(kled_oe), 32'hF);

    // second frame held while pending: accepted the cycle after the swap
    frame_valid = 1'b1;
    frame_data  = 16'h00F0;
    cyc();
    frame_data  = 16'h0F00;
    chk("hold_ready", 32'(frame_ready), 32'h0);
    repeat (FP - 5) cyc();
    chk("hold_swap_ready", 32'(frame_ready), 32'h1);
    cyc();
    frame_valid = 1'b0;
    chk("hold_accept", 32'(frame_ready), 32'h0);
    repeat (FR + BC - 1) cyc();
    chk("a_r1_kled", 32'(kled_oe), 32'hF);
    repeat (FP - FR - BC) cyc();
    repeat (2 * FR + BC) cyc();
    chk("b_r2_kled", 32'(kled_oe), 32'hF);

    // disable during row 2 drive, then re-enable
    repeat (10) cyc();
    chk("dis_pre_aled", 32'(aled_o), 32'h4);
    enable = 1'b0;
    cyc();
    chk("dis_aled", 32'(aled_o), 32'h0);
    chk("dis_kled", 32'(kled_oe), 32'h0);
    repeat (3) cyc();
    enable = 1'b1;
    cyc();
    chk("reen_sync", 32'(frame_sync), 32'h1);
    repeat (BC) cyc();
    chk("reen_aled", 32'(aled_o), 32'h1);

    // async reset during drive, with a frame pending
    frame_valid = 1'b1;
    frame_data  = 16'hAAAA;
    cyc();
    frame_valid = 1'b0;
    repeat (9) cyc();
    chk("pre_rst_aled", 32'(aled_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_aled", 32'(aled_o), 32'h0);
    chk("async_kled", 32'(kled_oe), 32'h0);
    chk("async_ready", 32'(frame_ready), 32'h1);
    @(negedge clk);
    mreset();
    rst_n = 1'b1;
    repeat (FP + 1) cyc();
    chk("post_rst_sync", 32'(frame_sync), 32'h1);

`ifdef LEDSCAN_DIM_EN
    brightness  = 4'd3;
    frame_valid = 1'b1;
    frame_data  = 16'hFFFF;
    cyc();
    frame_valid = 1'b0;
    repeat (FP - 1) cyc();
    repeat (BC + 7) cyc();
    chk("dim_last_on", 32'(kled_oe), 32'hF);
    cyc();
    chk("dim_first_off", 32'(kled_oe), 32'h0);
    chk("dim_aled", 32'(aled_o), 32'h1);
    repeat (FP - BC - 8) cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
